// File: rtl/l1_ld_responder_if.sv
// l1_ld_responder_if
//  Bundles the walker-side load handshake and the memory-side refill
//  handshake of the L1 load responder.
//  slave  : the responder (l1_ld_responder)
//  master : the walker plus backing memory (the environment)
interface l1_ld_responder_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  // walker side
  logic [ADDR_W-1:0] l1_va_i;
  logic              l1_va_vld_i;
  logic              l1_cancel_i;
  logic [DATA_W-1:0] l1_pa_o;
  logic              l1_pa_vld_o;
  logic              busy_o;
  logic              drop_err_o;
  // memory side
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvld_i;

  modport slave (
    input  l1_va_i, l1_va_vld_i, l1_cancel_i,
    input  mem_gnt_i, mem_rdata_i, mem_rvld_i,
    output l1_pa_o, l1_pa_vld_o, busy_o, drop_err_o,
    output mem_req_o, mem_addr_o
  );

  modport master (
    output l1_va_i, l1_va_vld_i, l1_cancel_i,
    output mem_gnt_i, mem_rdata_i, mem_rvld_i,
    input  l1_pa_o, l1_pa_vld_o, busy_o, drop_err_o,
    input  mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/l1_ld_responder.sv
// l1_ld_responder
//  Responder end of the walker-to-L1 load interface. Direct-mapped,
//  one word per line. Hits answer one cycle after the request; misses
//  are refilled from the memory port and answered one cycle after the
//  refill data arrives. A cancelled load still returns exactly one
//  response pulse, with zero data.
//  Optional feature macro: L1_PERF_CNT_EN adds saturating hit/miss/cancel
//  counters (hit_cnt_o, miss_cnt_o, cancel_cnt_o).
module l1_ld_responder #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  l1_ld_responder_if.slave     bus
`ifdef L1_PERF_CNT_EN
  ,
  output logic [15:0]          hit_cnt_o,
  output logic [15:0]          miss_cnt_o,
  output logic [15:0]          cancel_cnt_o
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESP  = 3'd1,
    ST_MREQ  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_CRESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   va_q, va_d;          // latched word address
  logic                cancel_q, cancel_d;
  logic                drop_err_q, drop_err_d;
  logic [DATA_W-1:0]   pa_q, pa_d;
  logic                pa_vld_q, pa_vld_d;
  logic                busy_q, busy_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    line_tag_q  [LINES];
  logic [TAG_W-1:0]    line_tag_d  [LINES];
  logic [DATA_W-1:0]   line_data_q [LINES];
  logic [DATA_W-1:0]   line_data_d [LINES];

  logic [IDX_W-1:0]    req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic [IDX_W-1:0]    fill_idx_s;
  logic [TAG_W-1:0]    fill_tag_s;
  logic                hit_s;
  logic                cancel_eff_s;
  logic                hit_evt_s;
  logic                miss_evt_s;
  logic                cancel_evt_s;
  logic                unused_byte_off_s;

  // Address split of the incoming request and of the latched load.
  assign req_idx_s         = bus.l1_va_i[IDX_W+1:2];
  assign req_tag_s         = bus.l1_va_i[ADDR_W-1:IDX_W+2];
  assign fill_idx_s        = va_q[IDX_W-1:0];
  assign fill_tag_s        = va_q[ADDR_W-3:IDX_W];
  // Byte offset inside the word is meaningless for a word-aligned load.
  assign unused_byte_off_s = ^bus.l1_va_i[1:0];

  assign hit_s        = valid_q[req_idx_s] && (line_tag_q[req_idx_s] == req_tag_s);
  // A cancel arriving in the same cycle as the refill data still cancels.
  assign cancel_eff_s = cancel_q | bus.l1_cancel_i;

  // Next-state, datapath and array-update logic of the load FSM.
  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    cancel_d     = cancel_q;
    drop_err_d   = drop_err_q | (bus.l1_va_vld_i & busy_q);
    pa_d         = '0;
    pa_vld_d     = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    valid_d      = valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    hit_evt_s    = 1'b0;
    miss_evt_s   = 1'b0;
    cancel_evt_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.l1_va_vld_i) begin
          va_d     = bus.l1_va_i[ADDR_W-1:2];
          cancel_d = 1'b0;
          if (hit_s) begin
            state_d   = ST_RESP;
            pa_vld_d  = 1'b1;
            pa_d      = line_data_q[req_idx_s];
            hit_evt_s = 1'b1;
          end else begin
            state_d    = ST_MREQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_tag_s, req_idx_s, 2'b00};
            miss_evt_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      ST_MREQ: begin
        if (bus.mem_gnt_i) begin
          // Grant wins over a simultaneous cancel; the cancel is remembered.
          state_d   = ST_MWAIT;
          mem_req_d = 1'b0;
          cancel_d  = cancel_eff_s;
        end else if (bus.l1_cancel_i) begin
          state_d      = ST_CRESP;
          mem_req_d    = 1'b0;
          pa_vld_d     = 1'b1;
          cancel_evt_s = 1'b1;
        end else begin
          state_d = ST_MREQ;
        end
      end

      ST_MWAIT: begin
        if (bus.mem_rvld_i) begin
          // The refill is always installed, cancelled or not.
          line_tag_d[fill_idx_s]  = fill_tag_s;
          line_data_d[fill_idx_s] = bus.mem_rdata_i;
          valid_d[fill_idx_s]     = 1'b1;
          state_d                 = ST_RESP;
          pa_vld_d                = 1'b1;
          pa_d                    = cancel_eff_s ? '0 : bus.mem_rdata_i;
          cancel_evt_s            = cancel_eff_s;
          cancel_d                = 1'b0;
        end else begin
          cancel_d = cancel_eff_s;
        end
      end

      ST_CRESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        cancel_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      va_q       <= '0;
      cancel_q   <= 1'b0;
      drop_err_q <= 1'b0;
      pa_q       <= '0;
      pa_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      cancel_q   <= cancel_d;
      drop_err_q <= drop_err_d;
      pa_q       <= pa_d;
      pa_vld_q   <= pa_vld_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk_i) begin
    line_tag_q  <= line_tag_d;
    line_data_q <= line_data_d;
  end

  assign bus.l1_pa_o     = pa_q;
  assign bus.l1_pa_vld_o = pa_vld_q;
  assign bus.busy_o      = busy_q;
  assign bus.drop_err_o  = drop_err_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = mem_addr_q;

`ifdef L1_PERF_CNT_EN
  logic [15:0] hit_cnt_q,    hit_cnt_d;
  logic [15:0] miss_cnt_q,   miss_cnt_d;
  logic [15:0] cancel_cnt_q, cancel_cnt_d;

  // Saturating event counters.
  always_comb begin
    hit_cnt_d    = (hit_evt_s && (hit_cnt_q != 16'hFFFF))
                   ? hit_cnt_q + 16'd1 : hit_cnt_q;
    miss_cnt_d   = (miss_evt_s && (miss_cnt_q != 16'hFFFF))
                   ? miss_cnt_q + 16'd1 : miss_cnt_q;
    cancel_cnt_d = (cancel_evt_s && (cancel_cnt_q != 16'hFFFF))
                   ? cancel_cnt_q + 16'd1 : cancel_cnt_q;
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_cnt_q    <= 16'd0;
      miss_cnt_q   <= 16'd0;
      cancel_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
  assign cancel_cnt_o = cancel_cnt_q;
`else
  logic unused_evt_s;
  assign unused_evt_s = hit_evt_s ^ miss_evt_s ^ cancel_evt_s;
`endif

endmodule

// File: tb/tb_l1_ld_responder.sv
// tb_l1_ld_responder
//  Directed bench for l1_ld_responder. Inputs are driven 1 ns after the
//  rising edge and outputs are sampled at the same point, so every output
//  reflects the edge just taken.
module tb_l1_ld_responder;

  logic clk_i;
  logic reset_i;
  int   n_pass;
  int   n_total;

  l1_ld_responder_if #(.ADDR_W(28), .DATA_W(32)) bus ();

`ifdef L1_PERF_CNT_EN
  logic [15:0] hit_cnt_o, miss_cnt_o, cancel_cnt_o;
`endif

  l1_ld_responder #(.IDX_W(4), .ADDR_W(28), .DATA_W(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
`ifdef L1_PERF_CNT_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
    .cancel_cnt_o (cancel_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Present a one-cycle load request and take the edge.
  task automatic issue(input logic [27:0] addr);
    bus.l1_va_i     = addr;
    bus.l1_va_vld_i = 1'b1;
    cyc();
    bus.l1_va_vld_i = 1'b0;
  endtask

  // Grant the pending refill, idle one cycle, then deliver data.
  task automatic grant_and_fill(input logic [31:0] data);
    bus.mem_gnt_i   = 1'b1;
    cyc();
    bus.mem_gnt_i   = 1'b0;
    cyc();
    bus.mem_rdata_i = data;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b0;
    n_total++;
    if ({bus.l1_pa_vld_o, bus.busy_o, bus.drop_err_o, bus.mem_req_o} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.l1_pa_vld_o, bus.busy_o, bus.drop_err_o, bus.mem_req_o});
    else n_pass++;
    n_total++;
    if (bus.l1_pa_o !== 32'h0 || bus.mem_addr_o !== 28'h0)
      $display("FAIL reset_data got pa=%h addr=%h exp 0/0", bus.l1_pa_o, bus.mem_addr_o);
    else n_pass++;
  endtask

  task automatic test_miss_refill();
    issue(28'h0000040);
    n_total++;
    if ({bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o} !== 3'b110)
      $display("FAIL t1_req got=%b exp=110", {bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o});
    else n_pass++;
    n_total++;
    if (bus.mem_addr_o !== 28'h0000040)
      $display("FAIL t1_addr got=%h exp=0000040", bus.mem_addr_o);
    else n_pass++;
    bus.mem_gnt_i = 1'b1;
    cyc();
    bus.mem_gnt_i = 1'b0;
    n_total++;
    if ({bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o} !== 3'b010)
      $display("FAIL t1_gnt got=%b exp=010", {bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o});
    else n_pass++;
    cyc();
    bus.mem_rdata_i = 32'hDEADBEEF;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'hDEADBEEF)
      $display("FAIL t1_resp got vld=%b pa=%h exp 1/DEADBEEF", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.l1_pa_o !== 32'h0 || bus.busy_o !== 1'b0)
      $display("FAIL t1_idle got vld=%b pa=%h busy=%b exp 0/0/0",
               bus.l1_pa_vld_o, bus.l1_pa_o, bus.busy_o);
    else n_pass++;
  endtask

  task automatic test_hit();
    // A cancel in IDLE has no effect on the next load.
    bus.l1_cancel_i = 1'b1;
    cyc();
    bus.l1_cancel_i = 1'b0;
    issue(28'h0000040);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'hDEADBEEF || bus.mem_req_o !== 1'b0)
      $display("FAIL t2_hit got vld=%b pa=%h req=%b exp 1/DEADBEEF/0",
               bus.l1_pa_vld_o, bus.l1_pa_o, bus.mem_req_o);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL t2_after got vld=%b req=%b busy=%b exp 0/0/0",
               bus.l1_pa_vld_o, bus.mem_req_o, bus.busy_o);
    else n_pass++;
`ifdef L1_PERF_CNT_EN
    n_total++;
    if (hit_cnt_o !== 16'd1 || miss_cnt_o !== 16'd1 || cancel_cnt_o !== 16'd0)
      $display("FAIL perf_cnt got hit=%0d miss=%0d cancel=%0d exp 1/1/0",
               hit_cnt_o, miss_cnt_o, cancel_cnt_o);
    else n_pass++;
`endif
  endtask

  task automatic test_evict();
    issue(28'h0000080);
    n_total++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 28'h0000080)
      $display("FAIL t3_miss80 got req=%b addr=%h exp 1/0000080", bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    grant_and_fill(32'h12345678);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h12345678)
      $display("FAIL t3_resp80 got vld=%b pa=%h exp 1/12345678", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
    issue(28'h0000040);
    n_total++;
    if (bus.mem_req_o !== 1'b1 || bus.l1_pa_vld_o !== 1'b0 || bus.mem_addr_o !== 28'h0000040)
      $display("FAIL t3_evicted got req=%b vld=%b addr=%h exp 1/0/0000040",
               bus.mem_req_o, bus.l1_pa_vld_o, bus.mem_addr_o);
    else n_pass++;
    grant_and_fill(32'hCAFEF00D);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'hCAFEF00D)
      $display("FAIL t3_resp40 got vld=%b pa=%h exp 1/CAFEF00D", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
  endtask

  task automatic test_cancel_mreq();
    issue(28'h0000104);
    cyc();                          // request held, no grant
    n_total++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 28'h0000104)
      $display("FAIL t4_hold got req=%b addr=%h exp 1/0000104", bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    bus.l1_cancel_i = 1'b1;
    cyc();
    bus.l1_cancel_i = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h0 || bus.mem_req_o !== 1'b0)
      $display("FAIL t4_cresp got vld=%b pa=%h req=%b exp 1/0/0",
               bus.l1_pa_vld_o, bus.l1_pa_o, bus.mem_req_o);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL t4_idle got vld=%b busy=%b exp 0/0", bus.l1_pa_vld_o, bus.busy_o);
    else n_pass++;
    issue(28'h0000104);
    n_total++;
    if (bus.mem_req_o !== 1'b1 || bus.l1_pa_vld_o !== 1'b0)
      $display("FAIL t4_remiss got req=%b vld=%b exp 1/0", bus.mem_req_o, bus.l1_pa_vld_o);
    else n_pass++;
    grant_and_fill(32'hA5A5A5A5);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'hA5A5A5A5)
      $display("FAIL t4_fill got vld=%b pa=%h exp 1/A5A5A5A5", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
  endtask

  task automatic test_cancel_mwait();
    issue(28'h0000208);
    bus.mem_gnt_i   = 1'b1;
    cyc();
    bus.mem_gnt_i   = 1'b0;
    bus.l1_cancel_i = 1'b1;
    cyc();
    bus.l1_cancel_i = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.busy_o !== 1'b1)
      $display("FAIL t5_wait got vld=%b busy=%b exp 0/1", bus.l1_pa_vld_o, bus.busy_o);
    else n_pass++;
    bus.mem_rdata_i = 32'h0BADF00D;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h0)
      $display("FAIL t5_cresp got vld=%b pa=%h exp 1/0", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
    issue(28'h0000208);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h0BADF00D || bus.mem_req_o !== 1'b0)
      $display("FAIL t5_hit got vld=%b pa=%h req=%b exp 1/0BADF00D/0",
               bus.l1_pa_vld_o, bus.l1_pa_o, bus.mem_req_o);
    else n_pass++;
    cyc();
  endtask

  task automatic test_cancel_with_grant();
    issue(28'h000030C);
    bus.mem_gnt_i   = 1'b1;
    bus.l1_cancel_i = 1'b1;
    cyc();
    bus.mem_gnt_i   = 1'b0;
    bus.l1_cancel_i = 1'b0;
    n_total++;
    if ({bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o} !== 3'b010)
      $display("FAIL cg_mwait got=%b exp=010", {bus.mem_req_o, bus.busy_o, bus.l1_pa_vld_o});
    else n_pass++;
    bus.mem_rdata_i = 32'h00000077;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h0)
      $display("FAIL cg_resp got vld=%b pa=%h exp 1/0", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
    issue(28'h000030C);
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h00000077)
      $display("FAIL cg_hit got vld=%b pa=%h exp 1/00000077", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
  endtask

  task automatic test_drop();
    n_total++;
    if (bus.drop_err_o !== 1'b0)
      $display("FAIL t6_pre got drop=%b exp 0", bus.drop_err_o);
    else n_pass++;
    issue(28'h0000410);
    bus.mem_gnt_i = 1'b1;
    cyc();
    bus.mem_gnt_i = 1'b0;
    issue(28'h0000040);            // arrives during MWAIT
    n_total++;
    if (bus.drop_err_o !== 1'b1 || bus.mem_req_o !== 1'b0)
      $display("FAIL t6_drop got drop=%b req=%b exp 1/0", bus.drop_err_o, bus.mem_req_o);
    else n_pass++;
    bus.mem_rdata_i = 32'h55AA55AA;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b1 || bus.l1_pa_o !== 32'h55AA55AA)
      $display("FAIL t6_resp got vld=%b pa=%h exp 1/55AA55AA", bus.l1_pa_vld_o, bus.l1_pa_o);
    else n_pass++;
    cyc();
    cyc();
    n_total++;
    if ({bus.drop_err_o, bus.busy_o, bus.mem_req_o, bus.l1_pa_vld_o} !== 4'b1000)
      $display("FAIL t6_held got=%b exp=1000",
               {bus.drop_err_o, bus.busy_o, bus.mem_req_o, bus.l1_pa_vld_o});
    else n_pass++;
  endtask

  task automatic test_rvld_idle();
    bus.mem_rdata_i = 32'hFFFF0000;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.l1_pa_o !== 32'h0)
      $display("FAIL rvld_idle got vld=%b busy=%b pa=%h exp 0/0/0",
               bus.l1_pa_vld_o, bus.busy_o, bus.l1_pa_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    issue(28'h0000514);
    bus.mem_gnt_i = 1'b1;
    cyc();
    bus.mem_gnt_i = 1'b0;
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    n_total++;
    if ({bus.busy_o, bus.mem_req_o, bus.drop_err_o, bus.l1_pa_vld_o} !== 4'b0000)
      $display("FAIL rst_mid got=%b exp=0000",
               {bus.busy_o, bus.mem_req_o, bus.drop_err_o, bus.l1_pa_vld_o});
    else n_pass++;
    bus.mem_rdata_i = 32'h13579BDF;
    bus.mem_rvld_i  = 1'b1;
    cyc();
    bus.mem_rvld_i  = 1'b0;
    cyc();
    n_total++;
    if (bus.l1_pa_vld_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL rst_late_rvld got vld=%b busy=%b exp 0/0", bus.l1_pa_vld_o, bus.busy_o);
    else n_pass++;
    // Previously valid line must miss after reset.
    issue(28'h0000208);
    n_total++;
    if (bus.mem_req_o !== 1'b1 || bus.l1_pa_vld_o !== 1'b0)
      $display("FAIL rst_valid_clr got req=%b vld=%b exp 1/0", bus.mem_req_o, bus.l1_pa_vld_o);
    else n_pass++;
    bus.l1_cancel_i = 1'b1;
    cyc();
    bus.l1_cancel_i = 1'b0;
    cyc();
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    reset_i         = 1'b1;
    bus.l1_va_i     = 28'h0;
    bus.l1_va_vld_i = 1'b0;
    bus.l1_cancel_i = 1'b0;
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    bus.mem_rvld_i  = 1'b0;
    cyc();

    test_reset();
    test_miss_refill();
    test_hit();
    test_evict();
    test_cancel_mreq();
    test_cancel_mwait();
    test_cancel_with_grant();
    test_drop();
    test_rvld_idle();
    test_reset_mid_refill();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
